// File: rtl/ifft2d_inv_pkg.sv
// Shared types and helpers for the inverse 2D transform (8 columns x 2 rows).
// Word width and column count live here; every other file sizes itself from them.
package ifft2d_inv_pkg;

  localparam int unsigned DATALEN = 16;
  localparam int unsigned FFTCHNL = 8;
  // Headroom for a butterfly operand plus a twiddled term before halving.
  localparam int unsigned WIDE_W  = DATALEN + 2;

  typedef logic signed [DATALEN-1:0] word_t;
  typedef logic signed [WIDE_W-1:0]  wide_t;

  // Real part sits in the lower word so bus word 2k = re, 2k+1 = im.
  typedef struct packed {
    word_t im;
    word_t re;
  } cplx_t;

  typedef cplx_t [FFTCHNL-1:0]   row_t;   // one output beat, sample k at index k
  typedef cplx_t [2*FFTCHNL-1:0] tile_t;  // index 2c = X[0][c], 2c+1 = X[1][c]

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ROW1 = 1'b1
  } ser_state_e;

  // Bit-reversed input order for the 8-point DIT core.
  localparam logic [2:0] BITREV8 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  // round(2^(dlen-1)/sqrt(2)) = round(sqrt(2^(2*dlen-3))), integer-only.
  function automatic int unsigned c_inv_sqrt2(input int unsigned dlen);
    longint unsigned n;
    longint unsigned r;
    longint unsigned t;
    n = 64'd1 << (2 * dlen - 3);
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= n) r = t;
    end
    // (r + 0.5)^2 = r^2 + r + 0.25, so round up when the remainder exceeds r.
    if ((n - r * r) > r) r = r + 64'd1;
    return 32'(r);
  endfunction

  localparam int unsigned C_INV_SQRT2 = c_inv_sqrt2(DATALEN);

  function automatic cplx_t cplx_pack(input word_t re, input word_t im);
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

  function automatic wide_t widen(input word_t w);
    return WIDE_W'(w);
  endfunction

  // (a +/- b) >>> 1 with floor, truncated back to one word.
  function automatic word_t half_sum(input wide_t a, input wide_t b, input logic sub);
    wide_t s;
    s = sub ? (a - b) : (a + b);
    return DATALEN'(s >>> 1);
  endfunction

  // One butterfly leg: (p +/- t) / 2 where t is an already-twiddled operand.
  function automatic cplx_t bfly(input cplx_t p, input wide_t tr, input wide_t ti,
                                 input logic sub);
    return cplx_pack(half_sum(widen(p.re), tr, sub), half_sum(widen(p.im), ti, sub));
  endfunction

endpackage

// File: rtl/ifft2d_inv_if.sv
// Tile-in / row-out bus of the inverse 2D transform.
//   invalid/indata/inready : one 16-bin tile per accepted beat
//   outvalid/outlast/outdata: one 8-sample row per beat, outlast on row 1
//   overflow                : sticky, a tile was offered while not ready
interface ifft2d_inv_if;
  import ifft2d_inv_pkg::*;

  logic  invalid;
  tile_t indata;
  logic  inready;
  logic  outvalid;
  logic  outlast;
  row_t  outdata;
  logic  overflow;

  modport master (
    output invalid, indata,
    input  inready, outvalid, outlast, outdata, overflow
  );

  modport slave (
    input  invalid, indata,
    output inready, outvalid, outlast, outdata, overflow
  );

endinterface

// File: rtl/ifft2d_inv_idft8_row.sv
// 8-point radix-2 DIT inverse DFT, three registered stages, 1/8 overall scale.
//   clk, rstn            : clock, async active-low reset (clears valid pipeline and output)
//   in_valid/in_last     : row presented this cycle, in_last tags the row-1 beat
//   in_data              : natural-order frequency row
//   out_valid/out_last   : registered, three cycles after input
//   out_data             : natural-order spatial row
module idft8_row
  import ifft2d_inv_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  input  logic in_last,
  input  row_t in_data,
  output logic out_valid,
  output logic out_last,
  output row_t out_data
);

  localparam word_t C_W = DATALEN'(C_INV_SQRT2);

  // x * 1/sqrt(2): full-width product, floor shift back to word scale.
  function automatic wide_t mul_c(input word_t x);
    logic signed [2*DATALEN-1:0] p;
    p = (2*DATALEN)'(x) * (2*DATALEN)'(C_W);
    return WIDE_W'(p >>> (DATALEN-1));
  endfunction

  row_t       s1_d, s1_q;
  row_t       s2_d, s2_q;
  row_t       s3_d, s3_q;
  logic [2:0] vld_d, vld_q;
  logic [2:0] last_d, last_q;

  // Stage 1: span-1 butterflies on bit-reversed inputs, unity twiddle.
  always_comb begin : stage1
    cplx_t p;
    cplx_t q;
    p    = '0;
    q    = '0;
    s1_d = '0;
    for (int m = 0; m < 4; m++) begin
      p = in_data[BITREV8[2*m]];
      q = in_data[BITREV8[2*m+1]];
      s1_d[2*m]   = bfly(p, widen(q.re), widen(q.im), 1'b0);
      s1_d[2*m+1] = bfly(p, widen(q.re), widen(q.im), 1'b1);
    end
  end

  // Stage 2: span-2 butterflies, twiddles 1 and +j.
  always_comb begin : stage2
    wide_t tr;
    wide_t ti;
    tr   = '0;
    ti   = '0;
    s2_d = '0;
    for (int g = 0; g < 8; g += 4) begin
      for (int j = 0; j < 2; j++) begin
        if (j == 0) begin
          tr = widen(s1_q[g+j+2].re);
          ti = widen(s1_q[g+j+2].im);
        end else begin
          tr = -widen(s1_q[g+j+2].im);
          ti = widen(s1_q[g+j+2].re);
        end
        s2_d[g+j]   = bfly(s1_q[g+j], tr, ti, 1'b0);
        s2_d[g+j+2] = bfly(s1_q[g+j], tr, ti, 1'b1);
      end
    end
  end

  // Stage 3: span-4 butterflies, twiddles e^{+j*pi*k/4}, k = 0..3.
  always_comb begin : stage3
    cplx_t q;
    wide_t cr;
    wide_t ci;
    wide_t tr;
    wide_t ti;
    q    = '0;
    cr   = '0;
    ci   = '0;
    tr   = '0;
    ti   = '0;
    s3_d = '0;
    for (int j = 0; j < 4; j++) begin
      q  = s2_q[j+4];
      cr = mul_c(q.re);
      ci = mul_c(q.im);
      case (j)
        0: begin
          tr = widen(q.re);
          ti = widen(q.im);
        end
        1: begin
          tr = cr - ci;
          ti = cr + ci;
        end
        2: begin
          tr = -widen(q.im);
          ti = widen(q.re);
        end
        default: begin
          tr = -cr - ci;
          ti = cr - ci;
        end
      endcase
      s3_d[j]   = bfly(s2_q[j], tr, ti, 1'b0);
      s3_d[j+4] = bfly(s2_q[j], tr, ti, 1'b1);
    end
  end

  always_comb begin : ctl_pipe
    vld_d  = {vld_q[1:0], in_valid};
    last_d = {last_q[1:0], in_last & in_valid};
  end

  always_ff @(posedge clk or negedge rstn) begin : ctl_regs
    if (!rstn) begin
      vld_q  <= '0;
      last_q <= '0;
      s3_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      s3_q   <= s3_d;
    end
  end

  // Inner data stages carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin : data_regs
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign out_valid = vld_q[2];
  assign out_last  = last_q[2];
  assign out_data  = s3_q;

endmodule

// File: rtl/ifft2d_inv.sv
// Inverse 2D transform for 8x2 tiles: column 2-point inverse butterflies,
// row serializer, and the 8-point inverse row core. Output scale is 1/16.
//   clk, rstn : clock, async active-low reset
//   bus       : slave side of ifft2d_inv_if (tile in, rows out, sticky overflow)
module ifft2d_inv
  import ifft2d_inv_pkg::*;
(
  input logic         clk,
  input logic         rstn,
  ifft2d_inv_if.slave bus
);

  ser_state_e state_d, state_q;
  logic       inready_d, inready_q;
  logic       overflow_d, overflow_q;
  logic       row1_pend_d, row1_pend_q;
  row_t       row0_d, row0_q;
  row_t       row1_d, row1_q;

  logic       accept_c;
  row_t       col_s_c;
  row_t       col_d_c;
  logic       core_vld_c;
  logic       core_last_c;
  row_t       core_data_c;

  logic       row_vld;
  logic       row_last;
  row_t       row_data;

  assign accept_c = bus.invalid & inready_q;

  // Column stage: s = (a+b)/2 feeds row 0, d = (a-b)/2 feeds row 1.
  always_comb begin : col_bfly
    col_s_c = '0;
    col_d_c = '0;
    for (int c = 0; c < FFTCHNL; c++) begin
      col_s_c[c] = bfly(bus.indata[2*c], widen(bus.indata[2*c+1].re),
                        widen(bus.indata[2*c+1].im), 1'b0);
      col_d_c[c] = bfly(bus.indata[2*c], widen(bus.indata[2*c+1].re),
                        widen(bus.indata[2*c+1].im), 1'b1);
    end
    row0_d = accept_c ? col_s_c : row0_q;
    row1_d = accept_c ? col_d_c : row1_q;
  end

  // Serializer: one cycle of ROW1 after each accept blocks the next tile.
  always_comb begin : ser_fsm
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_ROW1;
      ST_ROW1: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    inready_d   = (state_d == ST_IDLE);
    row1_pend_d = (state_q == ST_ROW1);
    overflow_d  = overflow_q | (bus.invalid & ~inready_q);
  end

  // Row 0 enters the core the cycle after accept, the held row 1 one cycle later.
  always_comb begin : core_feed
    core_vld_c  = (state_q == ST_ROW1) | row1_pend_q;
    core_last_c = row1_pend_q;
    core_data_c = (state_q == ST_ROW1) ? row0_q : row1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin : ctl_regs
    if (!rstn) begin
      state_q     <= ST_IDLE;
      inready_q   <= 1'b1;
      overflow_q  <= 1'b0;
      row1_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inready_q   <= inready_d;
      overflow_q  <= overflow_d;
      row1_pend_q <= row1_pend_d;
    end
  end

  always_ff @(posedge clk) begin : data_regs
    row0_q <= row0_d;
    row1_q <= row1_d;
  end

  idft8_row u_row (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (core_vld_c),
    .in_last   (core_last_c),
    .in_data   (core_data_c),
    .out_valid (row_vld),
    .out_last  (row_last),
    .out_data  (row_data)
  );

  assign bus.inready  = inready_q;
  assign bus.overflow = overflow_q;
  assign bus.outvalid = row_vld;
  assign bus.outlast  = row_last;
  assign bus.outdata  = row_data;

endmodule
